// File: rtl/aes192_word_loader.sv
// Word-serial front end for a combinational AES-192 core: shifts in 6 key + 4 plaintext words, waits SETTLE_CYCLES, streams 4 cipher words.
// Latency: out_valid rises SETTLE_CYCLES edges after the 4th plaintext word is accepted. Optional feature macro: AES192_KEY_REUSE_EN.
// Backpressure: in_ready is low while settling/sending; out_ready low holds out_data/out_last indefinitely.
module aes192_word_loader #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
`ifdef AES192_KEY_REUSE_EN
    input  logic         key_reuse,
`endif
    output logic [191:0] core_key,
    output logic [127:0] core_plain,
    input  logic [127:0] core_cipher,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD_KEY = 2'd0,
        LOAD_PT  = 2'd1,
        SETTLE   = 2'd2,
        SEND     = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t       state;
    logic [2:0]   wcnt;
    logic [3:0]   scnt;
    logic [1:0]   ocnt;
    logic [127:0] obuf;
    logic         in_acc;
    logic         out_acc;
    logic         reuse_hit;

    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign out_data = obuf[127:96];

`ifdef AES192_KEY_REUSE_EN
    logic key_loaded;
    assign reuse_hit = key_reuse && key_loaded;
`else
    assign reuse_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_KEY;
            wcnt       <= 3'd0;
            scnt       <= 4'd0;
            ocnt       <= 2'd0;
            obuf       <= '0;
            core_key   <= '0;
            core_plain <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
`ifdef AES192_KEY_REUSE_EN
            key_loaded <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_KEY: begin
                    // in_ready is held low through reset and rises on the first edge after release
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        if (reuse_hit) begin
                            // retained key: this word is already plaintext word 0
                            core_plain <= {core_plain[95:0], in_data};
                            wcnt       <= 3'd1;
                            state      <= LOAD_PT;
                        end else begin
                            core_key <= {core_key[159:0], in_data};
                            if (wcnt == 3'd5) begin
                                wcnt  <= 3'd0;
                                state <= LOAD_PT;
`ifdef AES192_KEY_REUSE_EN
                                key_loaded <= 1'b1;
`endif
                            end else begin
                                wcnt <= wcnt + 3'd1;
                            end
                        end
                    end
                end
                LOAD_PT: begin
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        core_plain <= {core_plain[95:0], in_data};
                        if (wcnt == 3'd3) begin
                            wcnt     <= 3'd0;
                            scnt     <= SETTLE_INIT;
                            state    <= SETTLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            wcnt <= wcnt + 3'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt == 4'd1) begin
                        obuf      <= core_cipher;
                        scnt      <= 4'd0;
                        ocnt      <= 2'd0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end else begin
                        scnt <= scnt - 4'd1;
                    end
                end
                SEND: begin
                    if (out_acc) begin
                        obuf <= {obuf[95:0], 32'h0};
                        if (ocnt == 2'd3) begin
                            ocnt      <= 2'd0;
                            state     <= LOAD_KEY;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            ocnt     <= ocnt + 2'd1;
                            out_last <= (ocnt == 2'd2);
                        end
                    end
                end
                default: state <= LOAD_KEY;
            endcase
        end
    end

endmodule
